// File: rtl/mouse_tracker.sv
// rtl/mouse_tracker.sv - PS/2 mouse packet assembler and clamped pointer position tracker
module mouse_tracker #(
    parameter int         SCREEN_WIDTH       = 1280,
    parameter int         SCREEN_HEIGHT      = 1024,
    parameter int         PACKET_TIMEOUT     = 2700000,
    parameter logic [3:0] REG_IDLE           = 4'd0,
    parameter logic [3:0] REG_MOUSE_POSITION = 4'd6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_available,
    input  logic [7:0]  byte_data,
    output logic [3:0]  register_index,
    output logic [22:0] register_value,
    output logic [1:0]  mouse_control,
    output logic [2:0]  buttons,
    output logic        packet_error
);
    localparam int CW = $clog2(PACKET_TIMEOUT + 1);
    localparam logic signed [11:0] X_MAX = 12'(SCREEN_WIDTH - 1);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  tmo_cnt;
    logic           x_ovf, y_ovf, x_sign, y_sign;
    logic [2:0]     btn_lat;
    logic [7:0]     b1, b2;
    logic [10:0]    x, nx;
    logic [9:0]     y, ny;
    logic signed [11:0] dx, dy, sum_x, sum_y;
    logic           in_packet, timeout, b0_slot, take_b0, take_b1, take_b2, drop;

    // A timed-out cycle doubles as a header slot so a coincident byte is never lost
    always_comb begin
        in_packet = (state == WAIT_B1) || (state == WAIT_B2);
        timeout   = in_packet && (tmo_cnt == CW'(PACKET_TIMEOUT - 1));
        b0_slot   = (state == WAIT_B0) || (state == UPDATE) || timeout;
        take_b0   = byte_available && b0_slot && byte_data[3];
        drop      = byte_available && b0_slot && !byte_data[3];
        take_b1   = byte_available && (state == WAIT_B1) && !timeout;
        take_b2   = byte_available && (state == WAIT_B2) && !timeout;
    end

    always_comb begin
        state_nx = state;
        if (take_b0)
            state_nx = WAIT_B1;
        else if (timeout)
            state_nx = WAIT_B0;
        else begin
            case (state)
                WAIT_B1: if (take_b1) state_nx = WAIT_B2;
                WAIT_B2: if (take_b2) state_nx = UPDATE;
                UPDATE:  state_nx = WAIT_B0;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        dx    = x_ovf ? 12'sd0 : $signed({{3{x_sign}}, x_sign, b1});
        dy    = y_ovf ? 12'sd0 : $signed({{3{y_sign}}, y_sign, b2});
        sum_x = $signed({1'b0, x}) + dx;
        sum_y = $signed({2'b0, y}) - dy;
        if (sum_x[11])          nx = '0;
        else if (sum_x > X_MAX) nx = X_MAX[10:0];
        else                    nx = sum_x[10:0];
        if (sum_y[11])          ny = '0;
        else if (sum_y > Y_MAX) ny = Y_MAX[9:0];
        else                    ny = sum_y[9:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= WAIT_B0;
            tmo_cnt        <= '0;
            {x_ovf, y_ovf, x_sign, y_sign} <= '0;
            btn_lat        <= '0;
            b1             <= '0;
            b2             <= '0;
            x              <= 11'(SCREEN_WIDTH / 2);
            y              <= 10'(SCREEN_HEIGHT / 2);
            register_index <= REG_IDLE;
            register_value <= '0;
            mouse_control  <= 2'b00;
            buttons        <= 3'b000;
            packet_error   <= 1'b0;
        end else begin
            state        <= state_nx;
            packet_error <= timeout || drop;
            if (take_b0 || take_b1 || take_b2 || !in_packet || timeout)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + CW'(1);
            if (take_b0) begin
                {y_ovf, x_ovf, y_sign, x_sign} <= byte_data[7:4];
                btn_lat <= byte_data[2:0];
            end
            if (take_b1) b1 <= byte_data;
            if (take_b2) b2 <= byte_data;
            if (state == UPDATE) begin
                x              <= nx;
                y              <= ny;
                register_index <= REG_MOUSE_POSITION;
                register_value <= {2'b00, ny, nx};
                buttons        <= btn_lat;
                mouse_control  <= 2'b01;
            end else begin
                register_index <= REG_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mouse_tracker.sv
// tb/tb_mouse_tracker.sv - scoreboard bench for mouse_tracker with a packet-level reference model
module tb_mouse_tracker;
    localparam int T = 40;
    localparam int W = 1280;
    localparam int H = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_available = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [3:0]  register_index;
    logic [22:0] register_value;
    logic [1:0]  mouse_control;
    logic [2:0]  buttons;
    logic        packet_error;

    mouse_tracker #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .PACKET_TIMEOUT(T),
        .REG_IDLE(4'd0), .REG_MOUSE_POSITION(4'd6)
    ) dut (
        .clk(clk), .reset(reset), .byte_available(byte_available), .byte_data(byte_data),
        .register_index(register_index), .register_value(register_value),
        .mouse_control(mouse_control), .buttons(buttons), .packet_error(packet_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [22:0] val;
        logic [2:0]  btn;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          err_before;
    logic [22:0] last_val = '0;

    int          pcnt = 0;
    int          last_acc = 0;
    int          mx = W / 2;
    int          my = H / 2;
    logic [7:0]  pb[3];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        pcnt = 0;
        mx   = W / 2;
        my   = H / 2;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        bit timed_out;
        int ddx, ddy;
        timed_out = 0;
        if (pcnt > 0 && (cyc - last_acc) == T) begin
            timed_out = 1;
            pcnt = 0;
            exp_err++;
        end
        if (v) begin
            if (pcnt == 0) begin
                if (d[3]) begin
                    pb[0] = d; pcnt = 1; last_acc = cyc;
                end else if (!timed_out) begin
                    exp_err++;
                end
            end else begin
                pb[pcnt] = d; pcnt++; last_acc = cyc;
                if (pcnt == 3) begin
                    ddx = pb[0][6] ? 0 : (pb[0][4] ? int'(pb[1]) - 256 : int'(pb[1]));
                    ddy = pb[0][7] ? 0 : (pb[0][5] ? int'(pb[2]) - 256 : int'(pb[2]));
                    mx = clampi(mx + ddx, W - 1);
                    my = clampi(my - ddy, H - 1);
                    q.push_back('{cyc + 2, {2'b00, 10'(my), 11'(mx)}, pb[0][2:0]});
                    pcnt = 0;
                end
            end
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] d);
        @(negedge clk);
        byte_available = v;
        byte_data      = d;
        model_step(v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        tick(1'b1, a);
        tick(1'b1, b);
        tick(1'b1, c);
        idle(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_reg_index"}, register_index, 0);
        chk({tag, "_reg_value"}, register_value, 0);
        chk({tag, "_mouse_control"}, mouse_control, 0);
        chk({tag, "_buttons"}, buttons, 0);
        chk({tag, "_packet_error"}, packet_error, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        byte_available = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (packet_error === 1'b1) err_seen++;
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    chk("missed_write", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                if (register_index === 4'd6) begin
                    if (q.size() == 0) begin
                        chk("unexpected_write", register_value, 0);
                    end else begin
                        e = q.pop_front();
                        chk("write_cycle", cyc, e.cyc);
                        chk("write_value", register_value, e.val);
                        chk("write_buttons", buttons, e.btn);
                        chk("write_mouse_control", mouse_control, 1);
                    end
                    last_val = register_value;
                end else if (reset && register_index !== 4'd0) begin
                    chk("reg_index_idle", register_index, 0);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        idle(5);
        chk("idle_mouse_control", mouse_control, 0);

        send_pkt(8'h08, 8'h0A, 8'h05);
        chk("first_pos", last_val, {2'b00, 10'd507, 11'd650});
        chk("first_mouse_control", mouse_control, 1);
        chk("first_buttons", buttons, 0);

        do_reset();
        send_pkt(8'h18, 8'h00, 8'h38);
        chk("x_step1", last_val[10:0], 384);
        send_pkt(8'h18, 8'h00, 8'h38);
        chk("x_step2", last_val[10:0], 128);
        send_pkt(8'h18, 8'h00, 8'h38);
        chk("x_clamp_lo", last_val[10:0], 0);

        do_reset();
        send_pkt(8'h08, 8'h00, 8'hFF);
        chk("y_step1", last_val[20:11], 257);
        send_pkt(8'h08, 8'h00, 8'hFF);
        chk("y_step2", last_val[20:11], 2);
        send_pkt(8'h08, 8'h00, 8'hFF);
        chk("y_clamp_lo", last_val[20:11], 0);

        err_before = err_seen;
        tick(1'b1, 8'h00);
        idle(2);
        chk("drop_err", err_seen - err_before, 1);
        send_pkt(8'h09, 8'h00, 8'h00);
        chk("btn_left", buttons, 3'b001);
        chk("unchanged_pos", last_val, {2'b00, 10'd0, 11'd640});

        err_before = err_seen;
        tick(1'b1, 8'h08);
        tick(1'b1, 8'h01);
        idle(T + 3);
        chk("timeout_err", err_seen - err_before, 1);
        send_pkt(8'h08, 8'h00, 8'h00);

        send_pkt(8'h28, 8'h00, 8'h00);
        chk("y_up", last_val[20:11], 256);
        send_pkt(8'h48, 8'hFF, 8'h10);
        chk("x_ovf_pos", last_val, {2'b00, 10'd240, 11'd640});

        // timeout and a new header strobed in the very same cycle
        err_before = err_seen;
        tick(1'b1, 8'h08);
        idle(T - 1);
        tick(1'b1, 8'h09);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h00);
        idle(3);
        chk("coincident_timeout_err", err_seen - err_before, 1);
        chk("coincident_btn", buttons, 3'b001);

        tick(1'b1, 8'h08);
        tick(1'b1, 8'h01);
        @(posedge clk);
        #3;
        reset = 1'b0;
        byte_available = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        reset = 1'b1;
        send_pkt(8'h08, 8'h00, 8'h00);
        chk("post_reset_pos", last_val, {2'b00, 10'd512, 11'd640});

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] d;
            bit v;
            if ($urandom_range(0, 59) == 0) idle(T - 2 + $urandom_range(0, 3));
            d = 8'($urandom);
            if (pcnt == 0 && $urandom_range(0, 5) != 0) d[3] = 1'b1;
            if ($urandom_range(0, 3) == 0) d[7:6] = 2'b00;
            v = ($urandom_range(0, 3) != 0);
            tick(v, d);
        end
        idle(T + 5);
        chk("total_errors", err_seen, exp_err);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
